score_display_module: RTL and testbench
=======================================

Name: score_display_module

Overview:
- Downstream consumer of the game FSM's score.
- Converts a binary score to 4 BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits onto the 11-bit 7-segment bus that drives the display pins: 7 segments plus 4 digit enables.
- Sits between fsm_module's score counter and the board pins, replacing any combinational score decode.

Parameters:
- CLK_FREQ_HZ, 200_000_000, input clock frequency.
- REFRESH_HZ, 1000, full 4-digit frame rate. Digit slot length DIGIT_TICKS = CLK_FREQ_HZ/(4*REFRESH_HZ), 50_000 cycles at default.
- SCORE_W, 14, binary score width; values above 9999 saturate.

Ports:
- i_clk  in  1  system clock, posedge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_score  in  SCORE_W  binary score from the FSM.
- i_score_valid  in  1  1-cycle strobe: i_score is a new value to display.
- i_blank  in  1  1 = force all segments and digits off (level, sampled each cycle).
- o_display_score  out  11  [6:0] segments a..g, active-low; [10:7] digit enables, active-low, bit7 = units ... bit10 = thousands.
- o_busy  out  1  conversion in progress.

Behaviour:
Reset (async assert, sync release):
- o_display_score = 11'h7FF, o_busy = 0.
- Shown BCD register = 0000; digit index = 0; refresh counter = 0; pending flag = 0; FSM = IDLE.

Conversion FSM (IDLE -> SHIFT -> COMMIT -> IDLE):
- IDLE: on i_score_valid, latch min(i_score, 9999) into the shift register and clear the 16-bit BCD accumulator; next state SHIFT.
- SHIFT: exactly SCORE_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left 1 with the binary MSB entering the BCD LSB.
- COMMIT: 1 cycle; accumulator copied to the shown BCD register atomically. Next state is SHIFT if the pending flag is set, else IDLE.
- Latency: strobe in cycle N -> o_busy = 1 from N+1; shown register updated at the end of cycle N+SCORE_W+1; o_busy = 0 from N+SCORE_W+2.
- o_busy = 1 in SHIFT and COMMIT only.
- Valid while busy: value saturated and stored in a pending register, pending flag set. Last write wins if several arrive.
- In COMMIT with pending set: the pending value loads directly, pending flag clears, and the next conversion runs back-to-back (o_busy stays 1).
- Valid in the same cycle as COMMIT: treated as pending.
- Shown digits never display a partially converted value.

Refresh:
- Counter counts 0..DIGIT_TICKS-1 and wraps.
- On wrap, the digit index advances 0->1->2->3->0.
- Output registered: one cycle after the index changes, o_display_score reflects the new digit.
- Exactly one enable bit is low per slot unless the digit is blanked.

Leading-zero blanking:
- Thousands, hundreds and tens are blanked (segments 7'h7F, enable bit held high) when that digit and all digits above it are 0.
- Units always shown; score 0 displays "0".

Segment code, active-low, bit0 = a:
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10 (hex).
- Non-BCD values cannot occur; default to 7F.

i_blank = 1:
- Output 11'h7FF from the next cycle.
- Conversion and refresh keep running; the output resumes on the current slot when released.

Reset mid-conversion:
- Everything returns to reset values; the pending value is discarded.

Decomposition:
- Shared game package holds:
  - SEG_* constants: 10 digit codes plus SEG_BLANK = 7'h7F.
  - DISP_OFF = 11'h7FF.
  - Typedef disp_state_t {IDLE, SHIFT, COMMIT}.
  - Typedef bcd4_t = logic [3:0][3:0].
- One sub-module, bin2bcd_seq, contains the double-dabble FSM and pending logic. It has a valid/busy/done interface and a bcd4_t output.
- The refresh scanner, blanking and segment decode stay in the top.

Test Plan:
All scenarios run with CLK_FREQ_HZ=400, REFRESH_HZ=25 (DIGIT_TICKS=4).
- Reset: assert i_rst_n=0 mid-slot -> o_display_score=11'h7FF immediately. After release, the first units slot shows {4'b1110, 7'h40}; slots 1-3 show 11'h7FF.
- Score 1234:
  - valid at cycle N -> o_busy=1 cycles N+1..N+15, 0 at N+16.
  - Subsequent slots show {1110,19}, {1101,30}, {1011,24}, {0111,79}.
- Score 7 -> only the units slot is active ({1110,78}); tens, hundreds and thousands slots output 11'h7FF. Score 105 -> hundreds shows 79, tens shows 40 (an internal zero is not blanked).
- Saturation: i_score=14'h3FFF -> displays 9999 (all slots show segment code 10).
- Back-to-back: valid 42 at N, then 17 at N+3 and 88 at N+5 -> 42 committed, then 88 (17 never shown). o_busy stays high continuously until 88 is committed.
- Blanking: i_blank=1 for 10 cycles while showing 56 -> output 11'h7FF throughout. On release, output resumes on the current digit slot with correct segments.

Source files
------------

// File: rtl/score_display_module_pkg.sv
// score_display_module_pkg: shared segment codes, display constants and BCD types for the score display.
package score_display_module_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [10:0] DISP_OFF = 11'h7FF;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} disp_state_t;
  typedef logic [3:0][3:0] bcd4_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic bcd4_t dabble_add3(input bcd4_t b);
    bcd4_t r;
    for (int i = 0; i < 4; i++) r[i] = (b[i] >= 4'd5) ? b[i] + 4'd3 : b[i];
    return r;
  endfunction
endpackage

// File: rtl/score_display_module_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter with a saturating input and a one-deep last-wins pending slot.
module bin2bcd_seq
  import score_display_module_pkg::*;
#(
  parameter int SCORE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [SCORE_W-1:0] i_bin,
  output logic               o_busy,
  output logic               o_done,
  output bcd4_t              o_bcd
);
  localparam int CNT_W = $clog2(SCORE_W + 1);

  disp_state_t        state_q;
  logic [SCORE_W-1:0] sh_q, pend_q, sat;
  logic               pend_v_q;
  logic [CNT_W-1:0]   cnt_q;
  bcd4_t              acc_q, acc_add;
  logic [16:0]        acc_sh;

  assign sat     = (32'(i_bin) > 32'd9999) ? SCORE_W'(9999) : i_bin;
  assign acc_add = dabble_add3(acc_q);
  assign acc_sh  = {acc_add, sh_q[SCORE_W-1]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          sh_q    <= sat;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: begin
          acc_q   <= acc_sh[15:0];
          sh_q    <= sh_q << 1;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CNT_W'(SCORE_W - 1)) ? COMMIT : SHIFT;
          if (i_valid) begin
            pend_q   <= sat;
            pend_v_q <= 1'b1;
          end
        end
        COMMIT: begin
          // A strobe landing in COMMIT queues behind an existing pending value, else starts straight away.
          acc_q    <= '0;
          cnt_q    <= '0;
          sh_q     <= pend_v_q ? pend_q : sat;
          state_q  <= (pend_v_q || i_valid) ? SHIFT : IDLE;
          pend_v_q <= pend_v_q && i_valid;
          if (pend_v_q && i_valid) pend_q <= sat;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == COMMIT);
  assign o_bcd  = acc_q;
endmodule

// File: rtl/score_display_module.sv
// score_display_module: converts the game score to BCD and scans it onto a 4-digit multiplexed 7-segment bus.
module score_display_module
  import score_display_module_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 200_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int SCORE_W     = 14
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SCORE_W-1:0] i_score,
  input  logic               i_score_valid,
  input  logic               i_blank,
  output logic [10:0]        o_display_score,
  output logic               o_busy
);
  localparam int DIGIT_TICKS = CLK_FREQ_HZ / (4 * REFRESH_HZ);
  localparam int TW          = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  logic          done;
  bcd4_t         acc, shown_q;
  logic [TW-1:0] tick_q;
  logic [1:0]    idx_q;
  logic [10:0]   disp_q, disp_d;
  logic [3:0]    lit;
  logic          wrap;

  bin2bcd_seq #(.SCORE_W(SCORE_W)) u_conv (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_score_valid),
    .i_bin   (i_score),
    .o_busy  (o_busy),
    .o_done  (done),
    .o_bcd   (acc)
  );

  // A digit lights when it or any more significant digit is non-zero; units always light.
  assign lit[3] = |shown_q[3];
  assign lit[2] = lit[3] | (|shown_q[2]);
  assign lit[1] = lit[2] | (|shown_q[1]);
  assign lit[0] = 1'b1;

  assign wrap   = (tick_q == TW'(DIGIT_TICKS - 1));
  assign disp_d = (i_blank || !lit[idx_q]) ? DISP_OFF
                                           : {~(4'b0001 << idx_q), seg_decode(shown_q[idx_q])};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shown_q <= '0;
      tick_q  <= '0;
      idx_q   <= '0;
      disp_q  <= DISP_OFF;
    end else begin
      if (done) shown_q <= acc;
      tick_q <= wrap ? '0 : tick_q + 1'b1;
      if (wrap) idx_q <= idx_q + 1'b1;
      disp_q <= disp_d;
    end
  end

  assign o_display_score = disp_q;
endmodule

// File: tb/tb_score_display_module.sv
// tb_score_display_module: directed checks of conversion latency, scanning, blanking and reset behaviour.
module tb_score_display_module;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] score = '0;
  logic        valid = 1'b0;
  logic        blank = 1'b0;
  logic [10:0] disp;
  logic        busy;
  int          cyc;
  int          checks = 0;
  int          failures = 0;
  logic [10:0] e42 [4] = '{11'h724, 11'h699, 11'h7FF, 11'h7FF};
  logic [10:0] e56 [4] = '{11'h702, 11'h692, 11'h7FF, 11'h7FF};

  always #5 clk = ~clk;

  score_display_module #(.CLK_FREQ_HZ(400), .REFRESH_HZ(25), .SCORE_W(14)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_score         (score),
    .i_score_valid   (valid),
    .i_blank         (blank),
    .o_display_score (disp),
    .o_busy          (busy)
  );

  // Posedges since reset release; the slot on screen after edge k is ((k-1)/4)%4.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  function automatic int slot_now();
    return ((cyc - 1) >> 2) & 3;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic frame(input string tag, input logic [10:0] e0, input logic [10:0] e1,
                       input logic [10:0] e2, input logic [10:0] e3);
    logic [10:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (((cyc - 1) & 3) == 0) chk($sformatf("%s_slot%0d", tag, slot_now()), disp, e[slot_now()]);
    end
  endtask

  task automatic strobe(input logic [13:0] v);
    @(negedge clk);
    score = v;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_disp", disp, 11'h7FF);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_units", disp, 11'h740);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_disp", disp, 11'h7FF);
    @(negedge clk);
    rst_n = 1'b1;
    frame("zero", 11'h740, 11'h7FF, 11'h7FF, 11'h7FF);

    strobe(14'd1234);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("busy1234_k%0d", k), busy, (k <= 15));
      @(negedge clk);
    end
    frame("s1234", 11'h719, 11'h6B0, 11'h5A4, 11'h3F9);

    strobe(14'd7);
    repeat (18) @(negedge clk);
    frame("s7", 11'h778, 11'h7FF, 11'h7FF, 11'h7FF);

    strobe(14'd105);
    repeat (18) @(negedge clk);
    frame("s105", 11'h712, 11'h6C0, 11'h5F9, 11'h7FF);

    strobe(14'h3FFF);
    repeat (18) @(negedge clk);
    frame("sat", 11'h710, 11'h690, 11'h590, 11'h390);

    strobe(14'd42);
    @(negedge clk);
    @(negedge clk);
    score = 14'd17;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    score = 14'd88;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int c = 6; c <= 31; c++) begin
      chk($sformatf("b2b_busy_c%0d", c), busy, (c <= 30));
      if (c >= 17) chk($sformatf("b2b_show42_c%0d", c), disp, e42[slot_now()]);
      @(negedge clk);
    end
    frame("s88", 11'h700, 11'h680, 11'h7FF, 11'h7FF);

    strobe(14'd56);
    repeat (20) @(negedge clk);
    blank = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("blank_k%0d", k), disp, 11'h7FF);
    end
    blank = 1'b0;
    @(negedge clk);
    chk("blank_release", disp, e56[slot_now()]);
    frame("s56", 11'h702, 11'h692, 11'h7FF, 11'h7FF);

    strobe(14'd1234);
    strobe(14'd5);
    #2 rst_n = 1'b0;
    #1 chk("midconv_rst_disp", disp, 11'h7FF);
    chk("midconv_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_busy_k%0d", k), busy, 1'b0);
    end
    frame("post_rst", 11'h740, 11'h7FF, 11'h7FF, 11'h7FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
